// File: rtl/reg_pkg.sv
// Shared constants and helpers for the byte-strobed register file.
package reg_pkg;

   localparam int unsigned DEF_WIDTH = 32;
   localparam int unsigned DEF_LANES = DEF_WIDTH / 8;
   localparam logic [DEF_WIDTH-1:0] DEF_RESET_VAL = '0;

   function automatic int unsigned addr_width(input int unsigned depth);
      return (depth <= 2) ? 1 : $clog2(depth);
   endfunction

   function automatic int unsigned byte_lanes(input int unsigned width);
      return width / 8;
   endfunction

endpackage

// File: rtl/reg_word.sv
// One storage word: async active-low reset, per-byte load enables.
module reg_word
   import reg_pkg::*;
#(
   parameter int unsigned WIDTH = DEF_WIDTH,
   parameter logic [WIDTH-1:0] RESET_VAL = '0,
   localparam int unsigned NB = byte_lanes(WIDTH)
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic [NB-1:0]    ld,
   input  logic [WIDTH-1:0] d,
   output logic [WIDTH-1:0] q
);

   logic [WIDTH-1:0] word_d;
   logic [WIDTH-1:0] word_q;

   always_comb begin
      word_d = word_q;
      for (int b = 0; b < int'(NB); b++) begin
         if (ld[b]) begin
            word_d[8*b +: 8] = d[8*b +: 8];
         end
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         word_q <= RESET_VAL;
      end else begin
         word_q <= word_d;
      end
   end

   assign q = word_q;

endmodule

// File: rtl/reg_file.sv
// DEPTH x WIDTH register file: one strobed write port, two
// combinational read ports with optional same-cycle forwarding.
module reg_file
   import reg_pkg::*;
#(
   parameter int unsigned WIDTH = DEF_WIDTH,
   parameter int unsigned DEPTH = 32,
   parameter bit BYPASS = 1'b1,
   parameter bit ZERO_REG = 1'b0,
   parameter logic [WIDTH-1:0] RESET_VAL = WIDTH'(DEF_RESET_VAL),
   localparam int unsigned AW = addr_width(DEPTH),
   localparam int unsigned NB = byte_lanes(WIDTH)
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic             we,
   input  logic [AW-1:0]    waddr,
   input  logic [WIDTH-1:0] wdata,
   input  logic [NB-1:0]    wstrb,
   input  logic [AW-1:0]    raddr0,
   input  logic [AW-1:0]    raddr1,
   output logic [WIDTH-1:0] rdata0,
   output logic [WIDTH-1:0] rdata1
);

   localparam logic [AW:0] DEPTH_C = (AW+1)'(DEPTH);

   logic [WIDTH-1:0] words [DEPTH];
   logic [AW-1:0]    ra [2];
   logic [WIDTH-1:0] rd [2];
   logic             w_in_range;
   logic             w_zero;
   logic             wr_ok;

   assign w_in_range = {1'b0, waddr} < DEPTH_C;
   assign w_zero     = ZERO_REG && (waddr == '0);
   assign wr_ok      = rst_n && we && w_in_range && !w_zero;

   for (genvar i = 0; i < int'(DEPTH); i++) begin : g_word
      if (ZERO_REG && i == 0) begin : g_zero
         assign words[i] = '0;
      end else begin : g_reg
         logic          hit;
         logic [NB-1:0] ld;

         assign hit = wr_ok && (waddr == AW'(i));
         assign ld  = hit ? wstrb : '0;

         reg_word #(
            .WIDTH     (WIDTH),
            .RESET_VAL (RESET_VAL)
         ) u_word (
            .clk   (clk),
            .rst_n (rst_n),
            .ld    (ld),
            .d     (wdata),
            .q     (words[i])
         );
      end
   end

   assign ra[0] = raddr0;
   assign ra[1] = raddr1;

   // Unstrobed bytes of a forwarded word still come from storage.
   always_comb begin
      for (int p = 0; p < 2; p++) begin
         rd[p] = '0;
         if ({1'b0, ra[p]} < DEPTH_C) begin
            rd[p] = words[ra[p]];
         end
         if (BYPASS && wr_ok && (ra[p] == waddr)) begin
            for (int b = 0; b < int'(NB); b++) begin
               if (wstrb[b]) begin
                  rd[p][8*b +: 8] = wdata[8*b +: 8];
               end
            end
         end
      end
   end

   assign rdata0 = rd[0];
   assign rdata1 = rd[1];

endmodule

// File: tb/tb_reg_file.sv
// Randomised bench for reg_file: two configurations driven in parallel.
module tb_reg_file;

   logic        clk;
   logic        rst_n;
   logic        we;
   logic [4:0]  waddr;
   logic [31:0] wdata;
   logic [3:0]  wstrb;
   logic [4:0]  raddr0;
   logic [4:0]  raddr1;
   logic [31:0] rd_a0, rd_a1, rd_b0, rd_b1;

   int vectors;
   int miscompares;

   logic [31:0] ma [32];
   logic [31:0] mb [20];

   reg_file #(
      .WIDTH(32), .DEPTH(32), .BYPASS(1'b1), .ZERO_REG(1'b0),
      .RESET_VAL(32'hDEADBEEF)
   ) u_a (
      .clk(clk), .rst_n(rst_n), .we(we), .waddr(waddr),
      .wdata(wdata), .wstrb(wstrb),
      .raddr0(raddr0), .raddr1(raddr1),
      .rdata0(rd_a0), .rdata1(rd_a1)
   );

   reg_file #(
      .WIDTH(32), .DEPTH(20), .BYPASS(1'b0), .ZERO_REG(1'b1),
      .RESET_VAL(32'h0)
   ) u_b (
      .clk(clk), .rst_n(rst_n), .we(we), .waddr(waddr),
      .wdata(wdata), .wstrb(wstrb),
      .raddr0(raddr0), .raddr1(raddr1),
      .rdata0(rd_b0), .rdata1(rd_b1)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic check(input string tag, input logic [31:0] got,
                        input logic [31:0] exp);
      vectors++;
      if (got !== exp) begin
         miscompares++;
         $display("FAIL %s t=%0t got=%h exp=%h", tag, $time, got, exp);
      end
   endtask

   function automatic logic [31:0] merge(input logic [31:0] old,
                                         input logic [31:0] nw,
                                         input logic [3:0] st);
      logic [31:0] v;
      v = old;
      for (int b = 0; b < 4; b++)
         if (st[b]) v[8*b +: 8] = nw[8*b +: 8];
      return v;
   endfunction

   function automatic logic [31:0] exp_rd(input bit is_b,
                                          input logic [4:0] a);
      int depth;
      logic [31:0] v;
      depth = is_b ? 20 : 32;
      if (int'(a) >= depth) return 32'h0;
      if (is_b && a == 5'd0) return 32'h0;
      v = is_b ? mb[a] : ma[a];
      if (!is_b && rst_n && we && waddr == a)
         v = merge(v, wdata, wstrb);
      return v;
   endfunction

   task automatic reset_model();
      foreach (ma[i]) ma[i] = 32'hDEADBEEF;
      foreach (mb[i]) mb[i] = 32'h0;
   endtask

   task automatic check_reads();
      check("a_rd0", rd_a0, exp_rd(1'b0, raddr0));
      check("a_rd1", rd_a1, exp_rd(1'b0, raddr1));
      check("b_rd0", rd_b0, exp_rd(1'b1, raddr0));
      check("b_rd1", rd_b1, exp_rd(1'b1, raddr1));
   endtask

   task automatic tick();
      @(posedge clk);
      if (rst_n && we) begin
         ma[waddr] = merge(ma[waddr], wdata, wstrb);
         if (waddr < 5'd20 && waddr != 5'd0)
            mb[waddr] = merge(mb[waddr], wdata, wstrb);
      end
      #1;
   endtask

   task automatic drive(input logic w, input logic [4:0] wa,
                        input logic [31:0] wd, input logic [3:0] ws,
                        input logic [4:0] r0, input logic [4:0] r1);
      we = w; waddr = wa; wdata = wd; wstrb = ws;
      raddr0 = r0; raddr1 = r1;
   endtask

   task automatic op(input logic w, input logic [4:0] wa,
                     input logic [31:0] wd, input logic [3:0] ws,
                     input logic [4:0] r0, input logic [4:0] r1);
      drive(w, wa, wd, ws, r0, r1);
      @(negedge clk);
      check_reads();
      tick();
   endtask

   task automatic sweep();
      for (int i = 0; i < 32; i++) begin
         drive(1'b0, 5'd0, 32'h0, 4'h0, 5'(i), 5'(31 - i));
         #1;
         check_reads();
      end
   endtask

   initial begin
      vectors = 0;
      miscompares = 0;
      rst_n = 1'b1;
      drive(1'b0, 5'd0, 32'h0, 4'h0, 5'd0, 5'd31);
      #2;
      rst_n = 1'b0;
      reset_model();
      #1;
      check("rst_imm", rd_a0, 32'hDEADBEEF);
      sweep();
      @(posedge clk);
      #1;
      rst_n = 1'b1;

      op(1'b1, 5'd5, 32'h12345678, 4'hF, 5'd5, 5'd4);
      op(1'b0, 5'd0, 32'h0, 4'h0, 5'd5, 5'd4);
      check("full_wr", rd_a0, 32'h12345678);
      check("neighbour", rd_a1, 32'hDEADBEEF);

      op(1'b1, 5'd5, 32'hAABBCCDD, 4'b0101, 5'd5, 5'd5);
      op(1'b0, 5'd0, 32'h0, 4'h0, 5'd5, 5'd5);
      check("strobe", rd_b0, 32'h12BB56DD);

      op(1'b1, 5'd7, 32'h0, 4'hF, 5'd7, 5'd7);
      drive(1'b1, 5'd7, 32'hCAFEF00D, 4'b0011, 5'd7, 5'd7);
      @(negedge clk);
      check_reads();
      check("byp_a", rd_a1, 32'h0000F00D);
      check("nobyp_b", rd_b1, 32'h0);
      tick();
      op(1'b0, 5'd0, 32'h0, 4'h0, 5'd7, 5'd7);
      check("post_b", rd_b0, 32'h0000F00D);

      op(1'b1, 5'd9, 32'h55AA55AA, 4'h0, 5'd9, 5'd9);
      op(1'b1, 5'd0, 32'hFFFFFFFF, 4'hF, 5'd0, 5'd0);
      op(1'b0, 5'd0, 32'h0, 4'h0, 5'd0, 5'd9);
      check("zero_b", rd_b0, 32'h0);
      op(1'b1, 5'd25, 32'h87654321, 4'hF, 5'd25, 5'd19);
      op(1'b0, 5'd0, 32'h0, 4'h0, 5'd25, 5'd25);
      check("range_b", rd_b0, 32'h0);

      for (int n = 0; n < 400; n++) begin
         op(1'($urandom_range(0, 1)), 5'($urandom_range(0, 31)),
            $urandom, 4'($urandom_range(0, 15)),
            5'($urandom_range(0, 31)), 5'($urandom_range(0, 31)));
      end
      sweep();

      drive(1'b1, 5'd3, 32'h11, 4'hF, 5'd3, 5'd3);
      @(negedge clk);
      check_reads();
      #2;
      rst_n = 1'b0;
      reset_model();
      #1;
      check_reads();
      check("rst_mid", rd_a0, 32'hDEADBEEF);
      tick();
      rst_n = 1'b1;
      @(negedge clk);
      check_reads();
      tick();
      op(1'b0, 5'd0, 32'h0, 4'h0, 5'd3, 5'd3);
      check("first_wr", rd_a0, 32'h11);
      check("first_wr_b", rd_b1, 32'h11);
      sweep();

      $display("== %0d vectors applied, %0d miscompares ==",
               vectors, miscompares);
      $finish;
   end

endmodule
